// File: rtl/if_id_buffer_if.sv
// Fetch/decode-side signal bundle for the IF/ID skid buffer.
// The buffer uses the slave modport; the fetch/decode environment uses master.
interface if_id_buffer_if;
  logic [31:0] i_address;
  logic [31:0] i_instruccion;
  logic        i_valid;
  logic        o_ready;
  logic        o_select;
  logic [31:0] o_branch_address;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_valid;
  logic        i_dec_ready;
  logic        i_flush;
  logic [1:0]  o_level;

  modport slave (
    input  i_address, i_instruccion, i_valid, i_dec_ready, i_flush,
    output o_ready, o_select, o_branch_address, o_pc, o_instr, o_valid, o_level
  );

  modport master (
    output i_address, i_instruccion, i_valid, i_dec_ready, i_flush,
    input  o_ready, o_select, o_branch_address, o_pc, o_instr, o_valid, o_level
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry in-order IF/ID buffer with optional jump redirect to fetch.
// Define IF_ID_JUMP_REDIRECT_EN to build jump detection and the o_select redirect.
module if_id_buffer (
  input  logic          i_clock,
  input  logic          i_reset,
  if_id_buffer_if.slave bus
);

  logic [31:0] mem_pc_q    [2];
  logic [31:0] mem_instr_q [2];
  logic [1:0]  wr_en;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  level_q, level_d;
  logic        select_q, select_d;
  logic [31:0] branch_q, branch_d;
  logic        push, pop;

  assign bus.o_ready = (level_q != 2'd2);
  assign bus.o_valid = (level_q != 2'd0);
  assign bus.o_level = level_q;
  assign bus.o_pc    = mem_pc_q[rd_ptr_q];
  assign bus.o_instr = mem_instr_q[rd_ptr_q];

  // A word arriving in the redirect cycle is on the wrong path and is dropped.
  assign push = bus.i_valid && bus.o_ready && !select_q && !bus.i_flush;
  assign pop  = bus.o_valid && bus.i_dec_ready && !bus.i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wr_en    = 2'b00;
    if (bus.i_flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      level_d  = 2'd0;
    end else begin
      if (push) begin
        wr_en[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 2'd1;
        2'b01:   level_d = level_q - 2'd1;
        default: level_d = level_q;
      endcase
    end
  end

`ifdef IF_ID_JUMP_REDIRECT_EN
  logic [31:0] pc_plus4;
  logic        is_jump;

  assign pc_plus4 = bus.i_address + 32'd4;
  assign is_jump  = (bus.i_instruccion[31:26] == 6'b000010);

  always_comb begin
    select_d = 1'b0;
    branch_d = branch_q;
    if (push && is_jump) begin
      select_d = 1'b1;
      branch_d = {pc_plus4[31:28], bus.i_instruccion[25:0], 2'b00};
    end
  end
`else
  always_comb begin
    select_d = 1'b0;
    branch_d = 32'h0;
  end
`endif

  assign bus.o_select         = select_q;
  assign bus.o_branch_address = branch_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
      select_q <= 1'b0;
      branch_q <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      select_q <= select_d;
      branch_q <= branch_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          mem_pc_q[gi]    <= 32'h0;
          mem_instr_q[gi] <= 32'h0;
        end else if (wr_en[gi]) begin
          mem_pc_q[gi]    <= bus.i_address;
          mem_instr_q[gi] <= bus.i_instruccion;
        end
      end
    end
  endgenerate

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have ports: i_clock  in  1  rising-edge clock, only clock domain.
REQ-002 SHALL have ports: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: i_address  in  32  PC of the fetched word, from IF.
REQ-004 SHALL have ports: i_instruccion  in  32  fetched instruction word, from IF.
REQ-005 SHALL have ports: i_valid  in  1  IF presents a valid word this cycle.
REQ-006 SHALL have ports: o_ready  out  1  buffer accepts a word this cycle; IF holds its PC while low.
REQ-007 SHALL have ports: o_select  out  1  redirect request to IF branch mux.
REQ-008 SHALL have ports: o_branch_address  out  32  redirect target, to IF i_branch_address.
REQ-009 SHALL have ports: o_pc, o_instr  out  32 each  head entry presented to decode.
REQ-010 SHALL have ports: o_valid  out  1  head entry valid.
REQ-011 SHALL have ports: i_dec_ready  in  1  decode consumes head this cycle.
REQ-012 SHALL have ports: i_flush  in  1  later-stage branch taken; discard all buffered words.
REQ-013 SHALL have ports: o_level  out  2  current occupancy, 0..2.

Function
REQ-014 SHALL implement a 2-entry FIFO of {pc, instr} pairs, in order.
REQ-015 SHALL push when i_valid && o_ready && !o_select && !i_flush.
REQ-016 SHALL pop when o_valid && i_dec_ready && !i_flush.
REQ-017 SHALL drive o_ready = (o_level != 2), combinationally from registered state only.
REQ-018 SHALL support simultaneous push and pop at level 1; the level stays 1 and the head becomes the new word.
REQ-019 SHALL present a pushed word on o_valid/o_pc/o_instr no earlier than the cycle after the push (1-cycle latency when empty).
REQ-020 SHALL hold o_pc/o_instr stable while o_valid && !i_dec_ready.
REQ-021 SHALL detect jumps on a pushed word: opcode i_instruccion[31:26] == 6'b000010.
REQ-022 SHALL on a jump push register o_select=1 for exactly the next cycle, with o_branch_address = {i_address[31:28]+0, i_instruccion[25:0], 2'b00} (upper bits taken from i_address+4).
REQ-023 SHALL in the o_select cycle drop any i_valid word (wrong path); the jump itself stays buffered.
REQ-024 SHALL on i_flush empty the FIFO (o_level=0, o_valid=0) at the next edge and suppress push, pop and a pending o_select; i_flush has priority over every other event.
REQ-025 SHALL hold o_select low and o_branch_address at its last value otherwise.
REQ-026 SHALL keep read/write pointers 1 bit wide, wrapping 1->0.

Reset
REQ-027 SHALL on i_reset at a rising edge set o_level=0, o_valid=0, o_select=0, o_branch_address=32'h0, o_pc=32'h0, o_instr=32'h0, and both pointers to 0.
REQ-028 SHALL give i_reset priority over i_flush, push and pop; reset mid-operation discards all content and any pending redirect.
REQ-029 SHALL drive o_ready=1 during the cycle after reset.

Configuration
REQ-030 SHALL compile jump detection only when macro IF_ID_JUMP_REDIRECT_EN is defined.
REQ-031 SHALL, with the macro undefined, tie o_select=0 and o_branch_address=32'h0 and never drop input words; FIFO behaviour is unchanged.

Verification
REQ-032 SHALL cover: reset, then push pc=0x0 instr=0x20080005 -> next cycle o_valid=1, o_pc=0x0, o_instr=0x20080005, o_level=1.
REQ-033 SHALL cover: i_dec_ready=0, three consecutive valid words -> o_ready=0 after the 2nd, 3rd not accepted, o_level=2, head unchanged.
REQ-034 SHALL cover: push pc=0x00400010 instr=0x08100020 (macro on) -> next cycle o_select=1, o_branch_address=0x00400080, the word presented at pc=0x00400014 is dropped.
REQ-035 SHALL cover: level 2, i_flush=1 together with i_valid and i_dec_ready -> next cycle o_level=0, o_valid=0, no push, no pop.
REQ-036 SHALL cover: level 1, simultaneous push and pop for 4 cycles -> o_level stays 1, words emerge in order, pointers wrap.
REQ-037 SHALL cover: macro off, same jump as REQ-034 -> o_select stays 0, the following word is pushed.
